regfile_wr_sched: RTL and testbench

Write-port scheduler for the 32×32 register file in the pipelined MIPS core. It shares the file's single write port between the pipeline write-back stage (WB) and the multi-cycle MULT/DIV unit (MC). MC results are buffered in a small FIFO. A pending-destination scoreboard lets the hazard unit stall readers of registers that still await an MC result. The block sits between WB/MC and the register file's reg_write/write_reg/write_data inputs.

---
 rtl/regfile_wr_sched_if.sv | 39 +++
 rtl/regfile_wr_sched.sv | 128 ++++++++++++
 tb/tb_regfile_wr_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_if.sv
// Write-port scheduler bus bundle: WB and MC requests, hazard lookups and the
// register-file write port.
interface regfile_wr_sched_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mc_issue;
    logic [ADDR_W-1:0] mc_issue_addr;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              busy1;
    logic              busy2;
    logic              stall_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data, mc_issue, mc_issue_addr,
               mc_valid, mc_addr, mc_data, q_addr1, q_addr2,
        input  wb_ready, mc_ready, busy1, busy2, stall_req,
               rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, mc_issue, mc_issue_addr,
               mc_valid, mc_addr, mc_data, q_addr1, q_addr2,
        output wb_ready, mc_ready, busy1, busy2, stall_req,
               rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Shares the register file's single write port between WB and a buffered
// MULT/DIV result stream, with a pending-destination scoreboard for hazards.
module regfile_wr_sched #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wr_sched_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned NREG  = 1 << ADDR_W;

    // Reset asserts asynchronously, releases on a clock edge after two flops.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [STV_W-1:0]      r_starve_cnt;
    logic [NREG-1:0]       r_pending;

    logic              w_empty;
    logic              w_full;
    logic              w_starve;
    logic              w_push;
    logic              w_head_gnt;
    logic              w_wb_gnt;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [NREG-1:0]   w_pending_nxt;
    logic              w_hit1;
    logic              w_hit2;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_starve    = (r_starve_cnt == STV_W'(STARVE_MAX));
    assign w_push      = bus.mc_valid & ~w_full;
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Grant arbitration and write-port mux.
    always_comb begin
        w_head_gnt    = 1'b0;
        w_wb_gnt      = 1'b0;
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        if (!w_empty && (w_starve || !bus.wb_valid)) begin
            w_head_gnt   = 1'b1;
            bus.rf_waddr = w_head_addr;
            bus.rf_wdata = w_head_data;
            bus.rf_we    = (w_head_addr != '0);
        end else if (bus.wb_valid) begin
            w_wb_gnt     = 1'b1;
            bus.rf_waddr = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
            bus.rf_we    = (bus.wb_addr != '0);
        end
        bus.wb_ready  = w_wb_gnt;
        bus.mc_ready  = ~w_full;
        bus.stall_req = w_starve;
    end

    // Busy lookups see both the scoreboard and results still queued.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_addr[i] == bus.q_addr1)) w_hit1 = 1'b1;
            if (r_fifo_vld[i] && (r_fifo_addr[i] == bus.q_addr2)) w_hit2 = 1'b1;
        end
        bus.busy1 = r_pending[bus.q_addr1] | w_hit1;
        bus.busy2 = r_pending[bus.q_addr2] | w_hit2;
    end

    // A fresh issue to the register being retired keeps it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_head_gnt) w_pending_nxt[w_head_addr] = 1'b0;
        if (bus.mc_issue && (bus.mc_issue_addr != '0))
            w_pending_nxt[bus.mc_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fifo_vld   <= '0;
            r_starve_cnt <= '0;
            r_pending    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_head_gnt) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_head_gnt)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_head_gnt) r_count <= r_count - CNT_W'(1);
            if (w_head_gnt) r_fifo_vld[r_rd_ptr] <= 1'b0;
            if (w_push)     r_fifo_vld[r_wr_ptr] <= 1'b1;
            if (w_empty || w_head_gnt)        r_starve_cnt <= '0;
            else if (!w_starve)               r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    // Payload storage needs no reset; r_fifo_vld qualifies every entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.mc_addr;
            r_fifo_data[r_wr_ptr] <= bus.mc_data;
        end
    end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: expected register-file writes are
// queued by the stimulus and matched by an independent write monitor.
module tb_regfile_wr_sched;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    wr_t  exp_q[$];

    regfile_wr_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wr_sched #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every committed write must match the next expectation.
    always @(negedge clk) begin
        if (bus.rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.a || bus.rf_wdata !== e.d) begin
                    failures++;
                    $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia);
        bus.wb_valid      = wv;
        bus.wb_addr       = wa;
        bus.wb_data       = wd;
        bus.mc_valid      = mv;
        bus.mc_addr       = ma;
        bus.mc_data       = md;
        bus.mc_issue      = iv;
        bus.mc_issue_addr = ia;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rf_we"},     32'(bus.rf_we),     32'd0);
        chk({tag, "_rf_waddr"},  32'(bus.rf_waddr),  32'd0);
        chk({tag, "_rf_wdata"},  bus.rf_wdata,       32'd0);
        chk({tag, "_wb_ready"},  32'(bus.wb_ready),  32'd0);
        chk({tag, "_mc_ready"},  32'(bus.mc_ready),  32'd1);
        chk({tag, "_busy1"},     32'(bus.busy1),     32'd0);
        chk({tag, "_busy2"},     32'(bus.busy2),     32'd0);
        chk({tag, "_stall_req"}, 32'(bus.stall_req), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;
        @(negedge clk);
        chk_reset_outputs("reset");
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // WB streaming to $5 with MC idle
        for (int k = 0; k < 3; k++) begin
            cyc();
            drv(1, 5, 32'h2A, 0, 0, 0, 0, 0);
            expect_wr(5, 32'h2A);
            @(negedge clk);
            chk("wb_stream_ready", 32'(bus.wb_ready),  32'd1);
            chk("wb_stream_we",    32'(bus.rf_we),     32'd1);
            chk("wb_stream_stall", 32'(bus.stall_req), 32'd0);
        end

        // Issue $9, result $9=100 one later, busy tracking
        cyc(); drv(0, 0, 0, 0, 0, 0, 1, 9); bus.q_addr1 = 5'd9;
        @(negedge clk); chk("busy_issue_cycle", 32'(bus.busy1), 32'd0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("busy_after_issue", 32'(bus.busy1), 32'd1);
        cyc(); drv(0, 0, 0, 1, 9, 32'd100, 0, 0);
        @(negedge clk);
        chk("mc_accept_ready", 32'(bus.mc_ready), 32'd1);
        chk("mc_no_bypass",    32'(bus.rf_we),    32'd0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0); expect_wr(9, 32'd100);
        @(negedge clk);
        chk("mc_write_cycle",  32'(bus.rf_we), 32'd1);
        chk("busy_during_wr",  32'(bus.busy1), 32'd1);
        cyc();
        @(negedge clk); chk("busy_after_wr", 32'(bus.busy1), 32'd0);

        // Starvation: one queued result against continuous WB
        cyc(); drv(1, 5, 32'h10, 1, 7, 32'h77, 0, 0); expect_wr(5, 32'h10);
        @(negedge clk); chk("starve_wb0_ready", 32'(bus.wb_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); drv(1, 5, 32'h10 + 32'(k), 0, 0, 0, 0, 0); expect_wr(5, 32'h10 + 32'(k));
            @(negedge clk);
            chk("starve_wb_ready", 32'(bus.wb_ready),  32'd1);
            chk("starve_pre",      32'(bus.stall_req), 32'd0);
        end
        cyc(); drv(1, 5, 32'h15, 0, 0, 0, 0, 0); expect_wr(7, 32'h77);
        @(negedge clk);
        chk("starve_stall",    32'(bus.stall_req), 32'd1);
        chk("starve_wb_block", 32'(bus.wb_ready),  32'd0);
        cyc(); expect_wr(5, 32'h15);
        @(negedge clk);
        chk("starve_release", 32'(bus.stall_req), 32'd0);
        chk("starve_resume",  32'(bus.wb_ready),  32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);

        // FIFO fill, back-pressure and ready recovery
        cyc(); drv(1, 6, 32'h60, 1, 10, 32'hA0, 0, 0); expect_wr(6, 32'h60);
        @(negedge clk); chk("fill_ready0", 32'(bus.mc_ready), 32'd1);
        cyc(); drv(1, 6, 32'h61, 1, 11, 32'hB0, 0, 0); expect_wr(6, 32'h61);
        @(negedge clk); chk("fill_ready1", 32'(bus.mc_ready), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            cyc(); drv(1, 6, 32'h60 + 32'(k), 1, 12, 32'hC0, 0, 0); expect_wr(6, 32'h60 + 32'(k));
            @(negedge clk); chk("full_not_ready", 32'(bus.mc_ready), 32'd0);
        end
        cyc(); drv(1, 6, 32'h65, 1, 12, 32'hC0, 0, 0); expect_wr(10, 32'hA0);
        @(negedge clk);
        chk("full_pop_stall", 32'(bus.stall_req), 32'd1);
        chk("full_pop_wb",    32'(bus.wb_ready),  32'd0);
        chk("full_pop_ready", 32'(bus.mc_ready),  32'd0);
        cyc(); expect_wr(6, 32'h65);
        @(negedge clk);
        chk("ready_after_pop", 32'(bus.mc_ready), 32'd1);
        chk("wb_after_pop",    32'(bus.wb_ready), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0); expect_wr(11, 32'hB0);
        @(negedge clk); chk("drain_b0", 32'(bus.rf_we), 32'd1);
        cyc(); expect_wr(12, 32'hC0);
        @(negedge clk); chk("drain_c0", 32'(bus.rf_we), 32'd1);
        cyc();
        @(negedge clk); chk("drained_idle", 32'(bus.rf_we), 32'd0);

        // Same-cycle issue and retire of $3; WB write to $0
        cyc(); drv(0, 0, 0, 0, 0, 0, 1, 3); bus.q_addr2 = 5'd3;
        cyc(); drv(0, 0, 0, 1, 3, 32'h33, 0, 0);
        @(negedge clk); chk("pend3_busy", 32'(bus.busy2), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 1, 3); expect_wr(3, 32'h33);
        @(negedge clk); chk("pend3_write", 32'(bus.rf_we), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("pend3_set_wins", 32'(bus.busy2), 32'd1);
        cyc(); drv(1, 0, 32'hFF, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_wb_ready", 32'(bus.wb_ready), 32'd1);
        chk("r0_rf_we",    32'(bus.rf_we),    32'd0);

        // Mid-operation reset with two queued results and pending bits
        cyc(); drv(1, 6, 32'h70, 1, 21, 32'd1, 1, 20); bus.q_addr1 = 5'd20; expect_wr(6, 32'h70);
        cyc(); drv(1, 6, 32'h71, 1, 22, 32'd2, 0, 0); expect_wr(6, 32'h71);
        @(negedge clk);
        chk("pre_rst_busy20", 32'(bus.busy1),    32'd1);
        chk("pre_rst_ready",  32'(bus.mc_ready), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        cyc(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            chk("post_rst_no_we", 32'(bus.rf_we),    32'd0);
            chk("post_rst_ready", 32'(bus.mc_ready), 32'd1);
            chk("post_rst_busy",  32'(bus.busy1),    32'd0);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
